// File: rtl/range_stream_driver_if.sv
// Bundle of the range_stream_driver buffer-load, playback and result signals.
// The master modport is the driver side; the slave modport is its user or bench.
interface range_stream_driver_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             clear;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] range_in;
  logic             error_in;
  logic             go;
  logic             finish;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             full;
  logic [CW-1:0]    count;
  logic             done;
  logic [WIDTH-1:0] result_range;
  logic             result_error;
  logic             start_err;
  logic             wr_drop;

  modport master (
    input  wr_en, wr_data, clear, start, abort, range_in, error_in,
    output go, finish, data_out, busy, full, count, done,
           result_range, result_error, start_err, wr_drop
  );

  modport slave (
    output wr_en, wr_data, clear, start, abort, range_in, error_in,
    input  go, finish, data_out, busy, full, count, done,
           result_range, result_error, start_err, wr_drop
  );
endinterface

// File: rtl/range_stream_driver.sv
// Buffers a frame of samples and plays it out as go / data / finish, then
// captures the returned range/error and reports them with a done pulse.
module range_stream_driver #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int RESULT_LAT = 1
) (
  input logic                   clock,
  input logic                   reset,
  range_stream_driver_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_GO, S_STREAM, S_FIN, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d, cnt_new;
  logic [CW-1:0]    rd_q, rd_d;
  logic [LW-1:0]    wcnt_q, wcnt_d;
  logic             abt_q, abt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             idle, wr_ok;
  logic [AW-1:0]    last_idx;

  logic             go_q, go_d, fin_q, fin_d, busy_q, busy_d, full_q, full_d;
  logic             done_q, done_d, re_q, re_d, serr_q, serr_d, wdrop_q, wdrop_d;
  logic [WIDTH-1:0] data_q, data_d, rr_q, rr_d;

  always_comb begin
    idle     = (state_q == S_IDLE);
    wr_ok    = idle && bus.wr_en && !bus.clear && (count_q != CW'(DEPTH));
    cnt_new  = (idle && bus.clear) ? '0 : count_q + CW'(wr_ok);
    last_idx = AW'(count_q - CW'(1));

    state_d = state_q;
    count_d = cnt_new;
    rd_d    = rd_q;
    wcnt_d  = wcnt_q;
    abt_d   = abt_q;
    rr_d    = rr_q;
    re_d    = re_q;
    serr_d  = 1'b0;
    // A write lost to a same-cycle clear is not reported as a drop.
    wdrop_d = bus.wr_en && !(idle && bus.clear) && !wr_ok;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (cnt_new >= CW'(2)) begin
            state_d = S_GO;
            abt_d   = 1'b0;
          end else begin
            serr_d  = 1'b1;
          end
        end
      end
      S_GO: begin
        if (bus.abort) begin
          state_d = S_FIN;
          abt_d   = 1'b1;
        end else if (count_q > CW'(2)) begin
          state_d = S_STREAM;
          rd_d    = CW'(1);
        end else begin
          state_d = S_FIN;
        end
      end
      S_STREAM: begin
        if (bus.abort) begin
          state_d = S_FIN;
          abt_d   = 1'b1;
        end else if (rd_q == count_q - CW'(2)) begin
          state_d = S_FIN;
        end else begin
          rd_d    = rd_q + CW'(1);
        end
      end
      S_FIN: begin
        state_d = abt_q ? S_IDLE : S_WAIT;
        wcnt_d  = '0;
      end
      S_WAIT: begin
        if (wcnt_q == LW'(RESULT_LAT - 1)) begin
          rr_d    = bus.range_in;
          re_d    = bus.error_in;
          state_d = S_DONE;
        end else begin
          wcnt_d  = wcnt_q + LW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        count_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    data_d = '0;
    unique case (state_d)
      S_GO:     data_d = mem_q[0];
      S_STREAM: data_d = mem_q[AW'(rd_d)];
      S_FIN:    data_d = abt_d ? data_q : mem_q[last_idx];
      default:  data_d = '0;
    endcase
    go_d   = (state_d == S_GO);
    fin_d  = (state_d == S_FIN);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    full_d = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      rd_q    <= '0;
      wcnt_q  <= '0;
      abt_q   <= 1'b0;
      go_q    <= 1'b0;
      fin_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
      rr_q    <= '0;
      re_q    <= 1'b0;
      serr_q  <= 1'b0;
      wdrop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      wcnt_q  <= wcnt_d;
      abt_q   <= abt_d;
      go_q    <= go_d;
      fin_q   <= fin_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      full_q  <= full_d;
      done_q  <= done_d;
      rr_q    <= rr_d;
      re_q    <= re_d;
      serr_q  <= serr_d;
      wdrop_q <= wdrop_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem_q[AW'(count_q)] <= bus.wr_data;
  end

  assign bus.go           = go_q;
  assign bus.finish       = fin_q;
  assign bus.data_out     = data_q;
  assign bus.busy         = busy_q;
  assign bus.full         = full_q;
  assign bus.count        = count_q;
  assign bus.done         = done_q;
  assign bus.result_range = rr_q;
  assign bus.result_error = re_q;
  assign bus.start_err    = serr_q;
  assign bus.wr_drop      = wdrop_q;
endmodule

// File: tb/tb_range_stream_driver.sv
// Directed bench for range_stream_driver (WIDTH=8, DEPTH=8, RESULT_LAT=1).
module tb_range_stream_driver;
  logic clock, reset;
  int checks = 0;
  int errors = 0;

  range_stream_driver_if #(.WIDTH(8), .DEPTH(8)) bus ();

  range_stream_driver #(.WIDTH(8), .DEPTH(8), .RESULT_LAT(1)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle boundary: inputs are applied and outputs observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_one(input logic [7:0] v);
    bus.wr_en = 1'b1; bus.wr_data = v;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({bus.go, bus.finish, bus.data_out, bus.busy, bus.full, bus.done} !== 13'd0) begin
      errors++; $display("FAIL reset_ctrl: got %0h want 0", {bus.go, bus.finish, bus.data_out, bus.busy, bus.full, bus.done});
    end
    checks++;
    if ({bus.count, bus.result_range, bus.result_error, bus.start_err, bus.wr_drop} !== 15'd0) begin
      errors++; $display("FAIL reset_stat: got %0h want 0", {bus.count, bus.result_range, bus.result_error, bus.start_err, bus.wr_drop});
    end
  endtask

  task automatic test_basic_frame();
    write_one(8'd3); write_one(8'd9); write_one(8'd1); write_one(8'd7);
    checks++;
    if (bus.count !== 4'd4) begin errors++; $display("FAIL basic_count: got %0d want 4", bus.count); end
    bus.start = 1'b1; bus.range_in = 8'hEE;
    tick(); bus.start = 1'b0;                                       // t+1
    checks++;
    if ({bus.go, bus.finish, bus.busy, bus.data_out} !== {3'b101, 8'd3}) begin
      errors++; $display("FAIL basic_go: got %0h want %0h", {bus.go, bus.finish, bus.busy, bus.data_out}, {3'b101, 8'd3});
    end
    tick();                                                         // t+2
    checks++;
    if ({bus.go, bus.finish, bus.data_out} !== {2'b00, 8'd9}) begin
      errors++; $display("FAIL basic_mid0: got %0h want %0h", {bus.go, bus.finish, bus.data_out}, {2'b00, 8'd9});
    end
    tick();                                                         // t+3
    checks++;
    if ({bus.go, bus.finish, bus.data_out} !== {2'b00, 8'd1}) begin
      errors++; $display("FAIL basic_mid1: got %0h want %0h", {bus.go, bus.finish, bus.data_out}, {2'b00, 8'd1});
    end
    tick();                                                         // t+4
    checks++;
    if ({bus.go, bus.finish, bus.data_out} !== {2'b01, 8'd7}) begin
      errors++; $display("FAIL basic_fin: got %0h want %0h", {bus.go, bus.finish, bus.data_out}, {2'b01, 8'd7});
    end
    tick(); bus.range_in = 8'd8; bus.error_in = 1'b0;               // t+5
    checks++;
    if ({bus.go, bus.finish, bus.done, bus.data_out} !== 11'd0) begin
      errors++; $display("FAIL basic_wait: got %0h want 0", {bus.go, bus.finish, bus.done, bus.data_out});
    end
    tick(); bus.range_in = 8'h33;                                   // t+6
    checks++;
    if ({bus.done, bus.result_range, bus.result_error} !== {1'b1, 8'd8, 1'b0}) begin
      errors++; $display("FAIL basic_done: got %0h want %0h", {bus.done, bus.result_range, bus.result_error}, {1'b1, 8'd8, 1'b0});
    end
    tick();                                                         // t+7
    checks++;
    if ({bus.done, bus.busy, bus.count, bus.result_range} !== {2'b00, 4'd0, 8'd8}) begin
      errors++; $display("FAIL basic_after: got %0h want %0h", {bus.done, bus.busy, bus.count, bus.result_range}, {2'b00, 4'd0, 8'd8});
    end
  endtask

  task automatic test_two_samples();
    write_one(8'd5); write_one(8'd5);
    bus.start = 1'b1;
    tick(); bus.start = 1'b0;                                       // t+1
    checks++;
    if ({bus.go, bus.finish, bus.data_out} !== {2'b10, 8'd5}) begin
      errors++; $display("FAIL two_go: got %0h want %0h", {bus.go, bus.finish, bus.data_out}, {2'b10, 8'd5});
    end
    tick(); bus.range_in = 8'd0; bus.error_in = 1'b1;               // t+2
    checks++;
    if ({bus.go, bus.finish, bus.data_out} !== {2'b01, 8'd5}) begin
      errors++; $display("FAIL two_fin: got %0h want %0h", {bus.go, bus.finish, bus.data_out}, {2'b01, 8'd5});
    end
    tick();                                                         // t+3
    tick(); bus.error_in = 1'b0; bus.range_in = 8'h77;              // t+4
    checks++;
    if ({bus.done, bus.result_range, bus.result_error} !== {1'b1, 8'd0, 1'b1}) begin
      errors++; $display("FAIL two_done: got %0h want %0h", {bus.done, bus.result_range, bus.result_error}, {1'b1, 8'd0, 1'b1});
    end
    tick();
  endtask

  task automatic test_full_frame();
    for (int i = 0; i < 8; i++) write_one(8'h10 + 8'(i));
    checks++;
    if ({bus.full, bus.count} !== {1'b1, 4'd8}) begin
      errors++; $display("FAIL full_flag: got %0h want %0h", {bus.full, bus.count}, {1'b1, 4'd8});
    end
    write_one(8'h99);
    checks++;
    if ({bus.wr_drop, bus.full, bus.count} !== {2'b11, 4'd8}) begin
      errors++; $display("FAIL full_drop: got %0h want %0h", {bus.wr_drop, bus.full, bus.count}, {2'b11, 4'd8});
    end
    bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    checks++;
    if (bus.wr_drop !== 1'b0) begin errors++; $display("FAIL full_drop_pulse: got %0b want 0", bus.wr_drop); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({bus.go, bus.finish, bus.data_out} !== {(i == 0), (i == 7), 8'h10 + 8'(i)}) begin
        errors++; $display("FAIL full_sample%0d: got %0h want %0h", i, {bus.go, bus.finish, bus.data_out}, {(i == 0), (i == 7), 8'h10 + 8'(i)});
      end
      tick();
    end
    bus.range_in = 8'h42;
    checks++;
    if ({bus.go, bus.finish, bus.data_out} !== 10'd0) begin
      errors++; $display("FAIL full_extra: got %0h want 0", {bus.go, bus.finish, bus.data_out});
    end
    tick();
    checks++;
    if ({bus.done, bus.result_range} !== {1'b1, 8'h42}) begin
      errors++; $display("FAIL full_done: got %0h want %0h", {bus.done, bus.result_range}, {1'b1, 8'h42});
    end
    tick(); tick();
  endtask

  task automatic test_start_err_clear();
    write_one(8'h21);
    bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    checks++;
    if ({bus.start_err, bus.go, bus.busy, bus.count} !== {3'b100, 4'd1}) begin
      errors++; $display("FAIL serr_pulse: got %0h want %0h", {bus.start_err, bus.go, bus.busy, bus.count}, {3'b100, 4'd1});
    end
    tick();
    checks++;
    if ({bus.start_err, bus.go} !== 2'b00) begin
      errors++; $display("FAIL serr_clear: got %0h want 0", {bus.start_err, bus.go});
    end
    bus.clear = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h55;
    tick(); bus.clear = 1'b0; bus.wr_en = 1'b0;
    checks++;
    if ({bus.count, bus.wr_drop} !== {4'd0, 1'b0}) begin
      errors++; $display("FAIL clear_count: got %0h want 0", {bus.count, bus.wr_drop});
    end
  endtask

  task automatic test_abort();
    int seen;
    write_one(8'd4); write_one(8'd8); write_one(8'd2); write_one(8'd6);
    bus.start = 1'b1;
    tick(); bus.start = 1'b0;                                       // t+1
    checks++;
    if ({bus.go, bus.data_out} !== {1'b1, 8'd4}) begin
      errors++; $display("FAIL abort_go: got %0h want %0h", {bus.go, bus.data_out}, {1'b1, 8'd4});
    end
    tick(); bus.abort = 1'b1;                                       // t+2
    tick(); bus.abort = 1'b0;                                       // t+3
    checks++;
    if ({bus.go, bus.finish, bus.data_out} !== {2'b01, 8'd8}) begin
      errors++; $display("FAIL abort_fin: got %0h want %0h", {bus.go, bus.finish, bus.data_out}, {2'b01, 8'd8});
    end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.done) seen++;
    end
    checks++;
    if ({seen[3:0], bus.busy, bus.count} !== {4'd0, 1'b0, 4'd4}) begin
      errors++; $display("FAIL abort_idle: got done=%0d busy=%0b count=%0d want 0 0 4", seen, bus.busy, bus.count);
    end
  endtask

  task automatic test_reset_mid_stream();
    int seen;
    bus.start = 1'b1;
    tick(); bus.start = 1'b0;                                       // t+1
    tick();                                                         // t+2
    checks++;
    if ({bus.busy, bus.go, bus.finish} !== 3'b100) begin
      errors++; $display("FAIL rst_stream: got %0h want 4", {bus.busy, bus.go, bus.finish});
    end
    reset = 1'b1;
    tick(); reset = 1'b0;
    checks++;
    if ({bus.go, bus.finish, bus.busy, bus.count, bus.data_out} !== 15'd0) begin
      errors++; $display("FAIL rst_mid: got %0h want 0", {bus.go, bus.finish, bus.busy, bus.count, bus.data_out});
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done || bus.go || bus.finish) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_quiet: got %0d active cycles want 0", seen); end
  endtask

  initial begin
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.clear = 1'b0; bus.start = 1'b0;
    bus.abort = 1'b0; bus.range_in = '0; bus.error_in = 1'b0;
    test_reset();
    test_basic_frame();
    test_two_samples();
    test_full_frame();
    test_start_err_clear();
    test_abort();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
